// File: rtl/uart_cmd_decoder.sv
// Decodes UART receive bytes (WASD/R keys and ANSI arrow escapes) into held move commands.
// Optional feature: define UART_CMD_UPPERCASE_EN so that uppercase W/S/A/D/R also decode in IDLE.
module uart_cmd_decoder #(
   parameter int ESC_TIMEOUT = 50000,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       i_rx_data,
   input  logic             i_rx_valid,
   input  logic             i_cmd_ack,
   output logic             o_cmd_valid,
   output logic [2:0]       o_cmd,
   output logic             o_overrun,
   output logic             o_bad_key,
   output logic [CNT_W-1:0] o_drop_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ESC  = 2'd1;
   localparam logic [1:0] S_CSI  = 2'd2;

   localparam logic [2:0] CMD_UP      = 3'd0;
   localparam logic [2:0] CMD_DOWN    = 3'd1;
   localparam logic [2:0] CMD_LEFT    = 3'd2;
   localparam logic [2:0] CMD_RIGHT   = 3'd3;
   localparam logic [2:0] CMD_RESTART = 3'd4;

   localparam int              TMR_W    = $clog2(ESC_TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ESC_TIMEOUT - 1);

   logic [1:0]       state, state_nx;
   logic [TMR_W-1:0] timer, timer_nx;

   logic       idle_valid, idle_bad, idle_esc;
   logic [2:0] idle_cmd;
   logic       dec_valid, dec_bad;
   logic [2:0] dec_cmd;

   // Meaning of a byte seen in IDLE; also reused for the byte that ends a non-CSI escape.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      idle_valid = 1'b0;
      idle_cmd   = CMD_UP;
      idle_bad   = 1'b0;
      idle_esc   = 1'b0;
      case (i_rx_data)
         8'h77: begin idle_valid = 1'b1; idle_cmd = CMD_UP;      end
         8'h73: begin idle_valid = 1'b1; idle_cmd = CMD_DOWN;    end
         8'h61: begin idle_valid = 1'b1; idle_cmd = CMD_LEFT;    end
         8'h64: begin idle_valid = 1'b1; idle_cmd = CMD_RIGHT;   end
         8'h72: begin idle_valid = 1'b1; idle_cmd = CMD_RESTART; end
`ifdef UART_CMD_UPPERCASE_EN
         8'h57: begin idle_valid = 1'b1; idle_cmd = CMD_UP;      end
         8'h53: begin idle_valid = 1'b1; idle_cmd = CMD_DOWN;    end
         8'h41: begin idle_valid = 1'b1; idle_cmd = CMD_LEFT;    end
         8'h44: begin idle_valid = 1'b1; idle_cmd = CMD_RIGHT;   end
         8'h52: begin idle_valid = 1'b1; idle_cmd = CMD_RESTART; end
`endif
         8'h1B:        idle_esc = 1'b1;
         8'h0D, 8'h0A: ;
         default:      idle_bad = 1'b1;
      endcase
   end

   always_comb begin
      state_nx  = state;
      timer_nx  = timer;
      dec_valid = 1'b0;
      dec_cmd   = CMD_UP;
      dec_bad   = 1'b0;
      if (i_rx_valid) begin
         timer_nx = '0;
         if (state == S_CSI) begin
            state_nx = S_IDLE;
            case (i_rx_data)
               8'h41:   begin dec_valid = 1'b1; dec_cmd = CMD_UP;    end
               8'h42:   begin dec_valid = 1'b1; dec_cmd = CMD_DOWN;  end
               8'h43:   begin dec_valid = 1'b1; dec_cmd = CMD_RIGHT; end
               8'h44:   begin dec_valid = 1'b1; dec_cmd = CMD_LEFT;  end
               default: dec_bad = 1'b1;
            endcase
         end else if (state == S_ESC && i_rx_data == 8'h5B) begin
            state_nx = S_CSI;
         end else begin
            dec_valid = idle_valid;
            dec_cmd   = idle_cmd;
            dec_bad   = idle_bad;
            state_nx  = idle_esc ? S_ESC : S_IDLE;
         end
      end else if (state != S_IDLE) begin
         if (timer == TMR_LAST) begin
            // A lone ESC is a legitimate keystroke; an unfinished CSI is not.
            state_nx = S_IDLE;
            timer_nx = '0;
            dec_bad  = (state == S_CSI);
         end else begin
            timer_nx = timer + TMR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         timer        <= '0;
         o_cmd_valid  <= 1'b0;
         o_cmd        <= CMD_UP;
         o_overrun    <= 1'b0;
         o_bad_key    <= 1'b0;
         o_drop_count <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state     <= state_nx;
         timer     <= timer_nx;
         o_overrun <= 1'b0;
         o_bad_key <= dec_bad;
         if (dec_valid) begin
            if (!o_cmd_valid || i_cmd_ack) begin
               o_cmd_valid <= 1'b1;
               o_cmd       <= dec_cmd;
            end else begin
               o_overrun <= 1'b1;
               if (o_drop_count != {CNT_W{1'b1}})
                  o_drop_count <= o_drop_count + CNT_W'(1);
            end
         end else if (o_cmd_valid && i_cmd_ack) begin
            o_cmd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: per-cycle vector table plus multi-cycle sequences.
// Expected values follow the UART_CMD_UPPERCASE_EN setting of the build.
module tb_uart_cmd_decoder;

   localparam int TO = 20;
`ifdef UART_CMD_UPPERCASE_EN
   localparam bit UPPER = 1'b1;
`else
   localparam bit UPPER = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] i_rx_data = 8'h00;
   logic       i_rx_valid = 1'b0;
   logic       i_cmd_ack = 1'b0;
   logic       o_cmd_valid;
   logic [2:0] o_cmd;
   logic       o_overrun;
   logic       o_bad_key;
   logic [7:0] o_drop_count;

   int checks = 0;
   int errors = 0;
   int bad_cnt = 0;
   int ovr_cnt = 0;

   uart_cmd_decoder #(.ESC_TIMEOUT(TO), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
      .i_cmd_ack(i_cmd_ack), .o_cmd_valid(o_cmd_valid), .o_cmd(o_cmd),
      .o_overrun(o_overrun), .o_bad_key(o_bad_key), .o_drop_count(o_drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rv;
      logic [7:0] d;
      logic       ack;
      logic       ev;
      logic [2:0] ec;
      logic       eb;
      logic       eo;
      logic [7:0] edc;
   } vec_t;

   vec_t vecs [25];

   function automatic vec_t mk(input logic rv, input logic [7:0] d, input logic ack,
                               input logic ev, input logic [2:0] ec, input logic eb,
                               input logic eo, input logic [7:0] edc);
      vec_t v;
      v.rv = rv; v.d = d; v.ack = ack; v.ev = ev; v.ec = ec; v.eb = eb; v.eo = eo; v.edc = edc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input logic rv, input logic [7:0] d, input logic ack);
      @(negedge clk);
      i_rx_valid = rv;
      i_rx_data  = d;
      i_cmd_ack  = ack;
      @(posedge clk);
      #1;
      bad_cnt += int'(o_bad_key);
      ovr_cnt += int'(o_overrun);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1; i_rx_valid = 1'b0; i_cmd_ack = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bad_cnt = 0;
      ovr_cnt = 0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " valid"}, o_cmd_valid, 1'b0);
      check({tag, " cmd"}, o_cmd, 3'd0);
      check({tag, " overrun"}, o_overrun, 1'b0);
      check({tag, " bad"}, o_bad_key, 1'b0);
      check({tag, " drop"}, o_drop_count, 8'd0);
   endtask

   initial begin
      //               rv  data   ack  ev  ec                 eb  eo  drop
      vecs[0]  = mk(1, 8'h77, 0, 1, 3'd0,              0, 0, 0);  // w
      vecs[1]  = mk(0, 8'h00, 1, 0, 3'd0,              0, 0, 0);  // ack clears
      vecs[2]  = mk(1, 8'h73, 0, 1, 3'd1,              0, 0, 0);  // s
      vecs[3]  = mk(1, 8'h61, 1, 1, 3'd2,              0, 0, 0);  // a in ack cycle
      vecs[4]  = mk(1, 8'h64, 1, 1, 3'd3,              0, 0, 0);  // d
      vecs[5]  = mk(1, 8'h72, 1, 1, 3'd4,              0, 0, 0);  // r
      vecs[6]  = mk(1, 8'h0D, 1, 0, 3'd4,              0, 0, 0);  // CR ignored
      vecs[7]  = mk(1, 8'h0A, 0, 0, 3'd4,              0, 0, 0);  // LF ignored
      vecs[8]  = mk(1, 8'h78, 0, 0, 3'd4,              1, 0, 0);  // x -> bad
      vecs[9]  = mk(1, 8'h57, 0, UPPER, UPPER ? 3'd0 : 3'd4, !UPPER, 0, 0);  // W
      vecs[10] = mk(0, 8'h00, 1, 0, UPPER ? 3'd0 : 3'd4, 0, 0, 0);
      vecs[11] = mk(0, 8'h00, 1, 0, UPPER ? 3'd0 : 3'd4, 0, 0, 0);  // stray ack
      vecs[12] = mk(1, 8'h1B, 0, 0, UPPER ? 3'd0 : 3'd4, 0, 0, 0);  // ESC
      vecs[13] = mk(1, 8'h77, 0, 1, 3'd0,              0, 0, 0);  // ESC w -> UP
      vecs[14] = mk(0, 8'h00, 1, 0, 3'd0,              0, 0, 0);
      vecs[15] = mk(1, 8'h1B, 0, 0, 3'd0,              0, 0, 0);
      vecs[16] = mk(1, 8'h5B, 0, 0, 3'd0,              0, 0, 0);
      vecs[17] = mk(1, 8'h42, 0, 1, 3'd1,              0, 0, 0);  // arrow down
      vecs[18] = mk(1, 8'h1B, 1, 0, 3'd1,              0, 0, 0);
      vecs[19] = mk(1, 8'h5B, 0, 0, 3'd1,              0, 0, 0);
      vecs[20] = mk(1, 8'h44, 0, 1, 3'd2,              0, 0, 0);  // arrow left
      vecs[21] = mk(1, 8'h1B, 0, 1, 3'd2,              0, 0, 0);
      vecs[22] = mk(1, 8'h5B, 0, 1, 3'd2,              0, 0, 0);
      vecs[23] = mk(1, 8'h43, 0, 1, 3'd2,              0, 1, 1);  // arrow right overruns
      vecs[24] = mk(0, 8'h00, 1, 0, 3'd2,              0, 0, 1);

      do_reset;
      check_reset_state("reset");
      for (int i = 0; i < 25; i++) begin
         step(vecs[i].rv, vecs[i].d, vecs[i].ack);
         check($sformatf("vec%0d valid", i), o_cmd_valid, vecs[i].ev);
         check($sformatf("vec%0d cmd", i), o_cmd, vecs[i].ec);
         check($sformatf("vec%0d bad", i), o_bad_key, vecs[i].eb);
         check($sformatf("vec%0d overrun", i), o_overrun, vecs[i].eo);
         check($sformatf("vec%0d drop", i), o_drop_count, vecs[i].edc);
      end

      // Command held without ack, then released.
      do_reset;
      step(1, 8'h77, 0);
      check("hold first", o_cmd_valid, 1'b1);
      for (int k = 0; k < 20; k++) begin
         step(0, 8'h00, 0);
         check("hold valid", o_cmd_valid, 1'b1);
         check("hold cmd", o_cmd, 3'd0);
      end
      step(0, 8'h00, 1);
      check("hold release", o_cmd_valid, 1'b0);

      // Spaced arrow sequence.
      do_reset;
      step(1, 8'h1B, 0); idle(9);
      step(1, 8'h5B, 0); idle(9);
      check("spaced pre valid", o_cmd_valid, 1'b0);
      step(1, 8'h43, 0);
      check("spaced valid", o_cmd_valid, 1'b1);
      check("spaced cmd", o_cmd, 3'd3);
      check("spaced bad count", bad_cnt, 0);

      // Overrun and counter saturation with back-to-back bytes.
      do_reset;
      step(1, 8'h64, 0);
      step(1, 8'h61, 0);
      check("ovr cmd", o_cmd, 3'd3);
      check("ovr pulse", o_overrun, 1'b1);
      check("ovr drop", o_drop_count, 8'd1);
      for (int k = 0; k < 300; k++) step(1, 8'h61, 0);
      step(0, 8'h00, 0);
      check("sat drop", o_drop_count, 8'd255);
      check("sat cmd", o_cmd, 3'd3);
      check("sat ovr pulses", ovr_cnt, 301);
      check("sat ovr idle", o_overrun, 1'b0);

      // Lone ESC timeout, then uppercase A in IDLE.
      do_reset;
      step(1, 8'h1B, 0);
      idle(TO + 2);
      check("esc timeout bad count", bad_cnt, 0);
      step(1, 8'h41, 0);
      check("after esc timeout valid", o_cmd_valid, UPPER);
      check("after esc timeout bad", o_bad_key, !UPPER);
      if (UPPER) check("after esc timeout cmd", o_cmd, 3'd2);

      // Gaps just under the timeout keep the sequence alive.
      do_reset;
      step(1, 8'h1B, 0); idle(TO - 2);
      step(1, 8'h5B, 0); idle(TO - 2);
      step(1, 8'h41, 0);
      check("slow arrow valid", o_cmd_valid, 1'b1);
      check("slow arrow cmd", o_cmd, 3'd0);
      check("slow arrow bad count", bad_cnt, 0);
      step(0, 8'h00, 1);

      // Unfinished CSI times out with one bad-key pulse.
      bad_cnt = 0;
      step(1, 8'h1B, 0);
      step(1, 8'h5B, 0);
      idle(TO + 2);
      check("csi timeout bad count", bad_cnt, 1);
      check("csi timeout valid", o_cmd_valid, 1'b0);
      step(1, 8'h73, 0);
      check("csi timeout then s", o_cmd, 3'd1);

      // Malformed CSI final byte.
      do_reset;
      step(1, 8'h1B, 0);
      step(1, 8'h5B, 0);
      step(1, 8'h5A, 0);
      check("csi bad pulse", o_bad_key, 1'b1);
      check("csi bad valid", o_cmd_valid, 1'b0);
      step(1, 8'h72, 0);
      check("csi bad then r valid", o_cmd_valid, 1'b1);
      check("csi bad then r cmd", o_cmd, 3'd4);
      check("csi bad then r bad", o_bad_key, 1'b0);

      // Reset mid-sequence with a pending command.
      do_reset;
      step(1, 8'h64, 0);
      step(1, 8'h1B, 0);
      step(1, 8'h5B, 0);
      do_reset;
      check_reset_state("mid reset");
      step(1, 8'h41, 0);
      check("mid reset A valid", o_cmd_valid, UPPER);
      check("mid reset A bad", o_bad_key, !UPPER);
      if (UPPER) check("mid reset A cmd", o_cmd, 3'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
